// File: rtl/mem_access_pkg.sv
// mem_access_pkg: FSM states, RV funct3 codes and lane-count helper for the MEM-stage load/store unit.
package mem_access_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic int lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational store byte-lane steering and load extract/extend.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int NB = lanes(DATA_WIDTH),
    localparam int LB = $clog2(NB)
) (
    input  logic [2:0]            funct3_i,
    input  logic [LB-1:0]         lane_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [NB-1:0]         web_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    int sz;
    logic [DATA_WIDTH-1:0] sh;

    // Store data is replicated across every lane; only web selects the lanes written.
    always_comb begin
        sz = 1 << funct3_i[1:0];
        for (int i = 0; i < NB; i++) begin
            web_o[i] = !(i >= int'(lane_i) && i < int'(lane_i) + sz);
            wdata_o[8*i +: 8] = wdata_i[8*(i % sz) +: 8];
        end
    end

    assign sh = rdata_i >> {lane_i, 3'b000};

    assign rdata_o = funct3_i[1:0] == 2'd0 ? (funct3_i[2] ? DATA_WIDTH'(sh[7:0])  : DATA_WIDTH'($signed(sh[7:0])))
                   : funct3_i[1:0] == 2'd1 ? (funct3_i[2] ? DATA_WIDTH'(sh[15:0]) : DATA_WIDTH'($signed(sh[15:0])))
                   : funct3_i[1:0] == 2'd2 ? (funct3_i[2] ? DATA_WIDTH'(sh[31:0]) : DATA_WIDTH'($signed(sh[31:0])))
                   : sh;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine with req/ack data-memory handshake and timeout.
// Optional MISALIGN_TRAP_EN: misaligned accesses are rejected instead of being force-aligned.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [2:0]              req_funct3_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    stall_o,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    dm_cs_o,
    output logic [ADDR_WIDTH-1:0]   dm_addr_o,
    output logic [DATA_WIDTH/8-1:0] dm_web_o,
    output logic [DATA_WIDTH-1:0]   dm_wdata_o,
    input  logic [DATA_WIDTH-1:0]   dm_rdata_i,
    input  logic                    dm_ack_i
);

    localparam int NB = lanes(DATA_WIDTH);
    localparam int LB = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NB-1:0]         web_q, web_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]            f3_q, f3_d;
    logic [LB-1:0]         lane_q, lane_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d, err_q, err_d;

    logic [LB-1:0]         lane_raw, mask, lane_a;
    logic                  f3_ok, illegal;
    logic [NB-1:0]         web_s;
    logic [DATA_WIDTH-1:0] wdata_s, ext;

    assign lane_raw = req_addr_i[LB-1:0];
    assign mask     = LB'((1 << req_funct3_i[1:0]) - 1);
    assign lane_a   = lane_raw & ~mask;
    assign f3_ok    = (req_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                   || (DATA_WIDTH == 64 && (req_funct3_i inside {F3_D, F3_WU}));
`ifdef MISALIGN_TRAP_EN
    assign illegal  = !f3_ok || (req_we_i && req_funct3_i[2]) || |(lane_raw & mask);
`else
    assign illegal  = !f3_ok || (req_we_i && req_funct3_i[2]);
`endif

    // One aligner serves store steering in IDLE and load extraction in ACCESS.
    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3_i (state_q == IDLE ? req_funct3_i : f3_q),
        .lane_i   (state_q == IDLE ? lane_a : lane_q),
        .wdata_i  (req_wdata_i),
        .rdata_i  (dm_rdata_i),
        .web_o    (web_s),
        .wdata_o  (wdata_s),
        .rdata_o  (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            web_q   <= '1;
            wdata_q <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            web_q   <= web_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        web_d   = web_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                if (illegal) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    state_d = ACCESS;
                    addr_d  = {req_addr_i[ADDR_WIDTH-1:LB], {LB{1'b0}}};
                    web_d   = req_we_i ? web_s : '1;
                    wdata_d = req_we_i ? wdata_s : '0;
                    f3_d    = req_funct3_i;
                    lane_d  = lane_a;
                    we_d    = req_we_i;
                    cnt_d   = '0;
                end
            end
            ACCESS: if (dm_ack_i) begin
                state_d = RESP;
                err_d   = 1'b0;
                rdata_d = we_q ? '0 : ext;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = RESP;
                err_d   = 1'b1;
                rdata_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o = state_q == IDLE;
    assign stall_o     = (state_q == IDLE && req_valid_i) || state_q == ACCESS;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign dm_cs_o     = state_q == ACCESS;
    assign dm_addr_o   = addr_q;
    assign dm_web_o    = web_q;
    assign dm_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus reset/stray-ack sequences for mem_access_unit (DW=32).
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_we, stall, rsp_valid, rsp_err, dm_cs, dm_ack;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rsp_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_web;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wdata),
        .stall_o(stall), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .dm_cs_o(dm_cs), .dm_addr_o(dm_addr), .dm_web_o(dm_web), .dm_wdata_o(dm_wdata),
        .dm_rdata_i(dm_rdata), .dm_ack_i(dm_ack)
    );

    typedef struct {
        string       nm;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          ack_at;
        logic        cs;
        logic [3:0]  web;
        logic [31:0] dwd, dad, rd;
        logic        err;
    } vec_t;

    vec_t vs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int got, exp_at;
        logic cs_seen, dm_ok, stall_ok;
        exp_at = !v.cs ? 1 : v.ack_at > 0 ? v.ack_at + 1 : TO + 1;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; f3 = v.f3; addr = v.addr; wdata = v.wdata;
        #1;
        chk({v.nm, " ready"}, 32'(req_ready), 32'd1);
        chk({v.nm, " stall0"}, 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        got = -1; cs_seen = 1'b0; dm_ok = 1'b1; stall_ok = 1'b1;
        for (int c = 1; c < 100; c++) begin
            if (rsp_valid) begin
                got = c;
                break;
            end
            cs_seen |= dm_cs;
            if (dm_cs && (dm_web !== v.web || dm_wdata !== v.dwd || dm_addr !== v.dad)) dm_ok = 1'b0;
            if (!stall) stall_ok = 1'b0;
            dm_ack = (c == v.ack_at);
            dm_rdata = v.rdata;
            @(negedge clk);
        end
        dm_ack = 1'b0;
        chk({v.nm, " latency"}, 32'(got), 32'(exp_at));
        chk({v.nm, " cs"}, 32'(cs_seen), 32'(v.cs));
        if (v.cs) begin
            chk({v.nm, " dm"}, 32'(dm_ok), 32'd1);
            chk({v.nm, " stall"}, 32'(stall_ok), 32'd1);
        end
        chk({v.nm, " err"}, 32'(rsp_err), 32'(v.err));
        chk({v.nm, " rdata"}, rsp_rdata, v.rd);
        chk({v.nm, " stall_resp"}, 32'(stall), 32'd0);
        @(negedge clk);
        chk({v.nm, " pulse"}, 32'(rsp_valid), 32'd0);
        chk({v.nm, " idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vs.push_back('{"sw",   1'b1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        3, 1'b1, 4'b0000, 32'hDEADBEEF, 32'h100, 32'h0,        1'b0});
        vs.push_back('{"sb",   1'b1, F3_B,  32'h103, 32'h000000A5, 32'h0,        1, 1'b1, 4'b0111, 32'hA5A5A5A5, 32'h100, 32'h0,        1'b0});
        vs.push_back('{"sh",   1'b1, F3_H,  32'h106, 32'h00001234, 32'h0,        2, 1'b1, 4'b0011, 32'h12341234, 32'h104, 32'h0,        1'b0});
        vs.push_back('{"lb",   1'b0, F3_B,  32'h102, 32'h0,        32'h00800000, 1, 1'b1, 4'b1111, 32'h0,        32'h100, 32'hFFFFFF80, 1'b0});
        vs.push_back('{"lbu",  1'b0, F3_BU, 32'h102, 32'h0,        32'h00800000, 1, 1'b1, 4'b1111, 32'h0,        32'h100, 32'h00000080, 1'b0});
        vs.push_back('{"lb3",  1'b0, F3_B,  32'h107, 32'h0,        32'h7F123456, 2, 1'b1, 4'b1111, 32'h0,        32'h104, 32'h0000007F, 1'b0});
        vs.push_back('{"lbu1", 1'b0, F3_BU, 32'h105, 32'h0,        32'h0000AB00, 1, 1'b1, 4'b1111, 32'h0,        32'h104, 32'h000000AB, 1'b0});
        vs.push_back('{"lh",   1'b0, F3_H,  32'h102, 32'h0,        32'h80010000, 2, 1'b1, 4'b1111, 32'h0,        32'h100, 32'hFFFF8001, 1'b0});
        vs.push_back('{"lhu",  1'b0, F3_HU, 32'h102, 32'h0,        32'h80010000, 2, 1'b1, 4'b1111, 32'h0,        32'h100, 32'h00008001, 1'b0});
        vs.push_back('{"lw",   1'b0, F3_W,  32'h200, 32'h0,        32'hCAFEF00D, 5, 1'b1, 4'b1111, 32'h0,        32'h200, 32'hCAFEF00D, 1'b0});
        vs.push_back('{"lw_to",1'b0, F3_W,  32'h300, 32'h0,        32'hFFFFFFFF, 0, 1'b1, 4'b1111, 32'h0,        32'h300, 32'h0,        1'b1});
        vs.push_back('{"ld32", 1'b0, F3_D,  32'h100, 32'h0,        32'h12345678, 1, 1'b0, 4'b1111, 32'h0,        32'h0,   32'h0,        1'b1});
        vs.push_back('{"sbu",  1'b1, F3_BU, 32'h100, 32'h55,       32'h0,        1, 1'b0, 4'b1111, 32'h0,        32'h0,   32'h0,        1'b1});
        vs.push_back('{"f3_7", 1'b0, 3'b111,32'h100, 32'h0,        32'h12345678, 1, 1'b0, 4'b1111, 32'h0,        32'h0,   32'h0,        1'b1});
`ifdef MISALIGN_TRAP_EN
        vs.push_back('{"lh_mis",1'b0,F3_H,  32'h101, 32'h0,        32'h12348765, 1, 1'b0, 4'b1111, 32'h0,        32'h0,   32'h0,        1'b1});
        vs.push_back('{"sw_mis",1'b1,F3_W,  32'h102, 32'h11223344, 32'h0,        2, 1'b0, 4'b1111, 32'h0,        32'h0,   32'h0,        1'b1});
`else
        vs.push_back('{"lh_mis",1'b0,F3_H,  32'h101, 32'h0,        32'h12348765, 1, 1'b1, 4'b1111, 32'h0,        32'h100, 32'hFFFF8765, 1'b0});
        vs.push_back('{"sw_mis",1'b1,F3_W,  32'h102, 32'h11223344, 32'h0,        2, 1'b1, 4'b0000, 32'h11223344, 32'h100, 32'h0,        1'b0});
`endif

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; f3 = '0; addr = '0; wdata = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst ready", 32'(req_ready), 32'd1);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_err", 32'(rsp_err), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst dm_cs", 32'(dm_cs), 32'd0);
        chk("rst dm_addr", dm_addr, 32'h0);
        chk("rst dm_web", 32'(dm_web), 32'hF);
        chk("rst dm_wdata", dm_wdata, 32'h0);
        req_valid = 1'b1;
        #1 chk("rst stall=req_valid", 32'(stall), 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray ack", 32'(rsp_valid), 32'd0);
        end
        dm_ack = 1'b0;

        foreach (vs[i]) run(vs[i]);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; f3 = F3_W; addr = 32'h400;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid cs before rst", 32'(dm_cs), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("mid cs async", 32'(dm_cs), 32'd0);
        @(negedge clk);
        chk("mid rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid cs", 32'(dm_cs), 32'd0);
        rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h12345678;
        @(negedge clk);
        dm_ack = 1'b0;
        chk("late ack rsp", 32'(rsp_valid), 32'd0);
        chk("late ack ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("late ack rsp2", 32'(rsp_valid), 32'd0);

        run(vs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
